// File: rtl/issue_scheduler.sv
// issue_scheduler: grants RS issue against single result-bus reservations and broadcasts wakeups.
// Define ISSUE_SCHED_PERF_EN to add saturating issue/stall performance counters.
module issue_scheduler #(
    parameter int ROB_TAG_LEN = 6,
    parameter int ALU_LAT     = 1,
    parameter int MUL_LAT     = 4,
    parameter int SCHED_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             rs_insn_ready,
    input  logic [ROB_TAG_LEN-1:0] rs_dst_tag0,
    input  logic [ROB_TAG_LEN-1:0] rs_dst_tag1,
    output logic [1:0]             issue,
    output logic                   wakeup,
    output logic [ROB_TAG_LEN-1:0] wakeup_tag,
    output logic                   wakeup_src,
    output logic [2:0]             inflight
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_issue_alu,
    output logic [31:0]            perf_issue_mul,
    output logic [31:0]            perf_bus_stall
`endif
);
    logic [SCHED_DEPTH-1:0] s_valid;
    logic [SCHED_DEPTH-1:0] s_src;
    logic [ROB_TAG_LEN-1:0] s_tag [SCHED_DEPTH];
    logic [SCHED_DEPTH:0]   v_ext;
    // A latency equal to the depth lands on the always-empty slot above the top.
    assign v_ext = {1'b0, s_valid};
    always_comb begin
        issue[0]   = !reset && rs_insn_ready[0] && !v_ext[ALU_LAT];
        issue[1]   = !reset && rs_insn_ready[1] && !v_ext[MUL_LAT];
        wakeup     = s_valid[0];
        wakeup_tag = s_valid[0] ? s_tag[0] : '0;
        wakeup_src = s_valid[0] ? s_src[0] : 1'b0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            s_valid  <= '0;
            s_src    <= '0;
            for (int k = 0; k < SCHED_DEPTH; k++) s_tag[k] <= '0;
            inflight <= '0;
        end else begin
            for (int k = 0; k < SCHED_DEPTH - 1; k++) begin
                s_valid[k] <= s_valid[k+1];
                s_src[k]   <= s_src[k+1];
                s_tag[k]   <= s_tag[k+1];
            end
            s_valid[SCHED_DEPTH-1] <= 1'b0;
            s_src[SCHED_DEPTH-1]   <= 1'b0;
            s_tag[SCHED_DEPTH-1]   <= '0;
            if (issue[0]) begin
                s_valid[ALU_LAT-1] <= 1'b1;
                s_src[ALU_LAT-1]   <= 1'b0;
                s_tag[ALU_LAT-1]   <= rs_dst_tag0;
            end
            if (issue[1]) begin
                s_valid[MUL_LAT-1] <= 1'b1;
                s_src[MUL_LAT-1]   <= 1'b1;
                s_tag[MUL_LAT-1]   <= rs_dst_tag1;
            end
            inflight <= inflight + 3'(issue[0]) + 3'(issue[1]) - 3'(s_valid[0]);
        end
    end
`ifdef ISSUE_SCHED_PERF_EN
    logic stall;
    assign stall = |(rs_insn_ready & ~issue);
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issue_alu <= '0;
            perf_issue_mul <= '0;
            perf_bus_stall <= '0;
        end else begin
            perf_issue_alu <= perf_issue_alu + {31'd0, issue[0] & ~&perf_issue_alu};
            perf_issue_mul <= perf_issue_mul + {31'd0, issue[1] & ~&perf_issue_mul};
            perf_bus_stall <= perf_bus_stall + {31'd0, stall & ~&perf_bus_stall};
        end
    end
`endif
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue unit for two reservation stations: RS0 feeds the single-cycle ALU, RS1 feeds the pipelined multiplier.
- Each cycle it decides which RS may issue, from each RS's ready flag and a reservation of the single wakeup/result bus.
- Drives each RS's `issue` input, then broadcasts `wakeup`/`wakeup_tag` exactly FU-latency cycles later.
- Selects which FU's result value goes onto the bus.

Parameters:
- ALU_LAT, 1, cycles from ALU issue to its wakeup. Must be >=1.
- MUL_LAT, 4, cycles from multiplier issue to its wakeup. Must be >=1 and != ALU_LAT.
- SCHED_DEPTH, 4, depth of the bus-reservation shift register. Equals max(ALU_LAT, MUL_LAT).

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  synchronous, active-high
- rs_insn_ready  in  2  per-RS "an instruction is ready" flag; bit0=ALU RS, bit1=MUL RS
- rs_dst_tag0  in  ROB_TAG_LEN  dst tag of the instruction RS0 would issue
- rs_dst_tag1  in  ROB_TAG_LEN  dst tag of the instruction RS1 would issue
- issue  out  2  combinational issue grant to each RS; the RS samples it at posedge
- wakeup  out  1  registered; result bus valid this cycle
- wakeup_tag  out  ROB_TAG_LEN  registered; tag broadcast on the bus
- wakeup_src  out  1  registered; 0=take value from ALU, 1=take value from multiplier
- inflight  out  3  registered; count of issued instructions not yet broadcast (0..SCHED_DEPTH)

Behaviour:
- State: sched[0..SCHED_DEPTH-1], each slot = {valid, tag, src}. sched[0] is this cycle's broadcast.
- Outputs from sched[0]:
  - wakeup = sched[0].valid.
  - wakeup_tag = sched[0].tag when valid, else 0.
  - wakeup_src = sched[0].src when valid, else 0.
- Grant rule (combinational), per RS i with latency L:
  - issue[i] = rs_insn_ready[i] && slot_free(L).
  - slot_free(L) = !sched[L].valid if L < SCHED_DEPTH, else 1. (sched[L] is the entry that shifts into slot L-1 next cycle.)
- Every posedge, when not in reset:
  - sched[k] <= sched[k+1] for k < SCHED_DEPTH-1; the top slot becomes invalid.
  - If issue[0]: sched[ALU_LAT-1] <= {1, rs_dst_tag0, 0}.
  - If issue[1]: sched[MUL_LAT-1] <= {1, rs_dst_tag1, 1}.
  - The issue write overrides the shift into that slot. It cannot collide, by the grant rule.
- Latency: issue[i] high in cycle t gives wakeup high in cycle t+L_i with that tag. With ALU_LAT=1, wakeup follows ALU issue by exactly one cycle, as the RS requires.
- Both RSs may issue in the same cycle. Their latencies differ, so their slots differ; no priority is needed.
- Conflict case: an ALU instruction is ready in cycle t while a multiplier issued at t-(MUL_LAT-ALU_LAT) owns the bus at t+ALU_LAT.
  - The ALU grant is withheld for that cycle; the earlier reservation always wins.
  - The RS holds its instruction and retries the next cycle.
- No issue is granted when rs_insn_ready[i]=0, whatever the slot state.
- inflight <= inflight + |issue| - sched[0].valid, where |issue| is the number of issue bits set (0..2). It never exceeds SCHED_DEPTH.
- Reset values (takes effect at the next posedge, including mid-operation):
  - All sched slots invalid.
  - wakeup=0, wakeup_tag=0, wakeup_src=0, inflight=0.
  - Pending broadcasts are dropped.
  - issue is forced to 0 while reset is high.
- Back-to-back: one ALU issue per cycle can be sustained indefinitely, giving a wakeup every cycle. A multiplier issue every cycle is also sustainable, since the multiplier is pipelined.

Optional Feature:
- Macro ISSUE_SCHED_PERF_EN.
- When defined, adds three 32-bit output counters, cleared on reset, saturating at all-ones:
  - perf_issue_alu: cycles with issue[0].
  - perf_issue_mul: cycles with issue[1].
  - perf_bus_stall: cycles where rs_insn_ready[i]=1 but issue[i]=0, for any i.
- When not defined, these ports and registers do not exist, and there is no other behavioural change.

Test Plan:
- Reset for 2 cycles, then rs_insn_ready=00 for 5 cycles -> issue=00, wakeup=0, wakeup_tag=0, inflight=0 throughout.
- rs_insn_ready=01, rs_dst_tag0=5 in cycle 3 only -> issue=01 in cycle 3; wakeup=1, tag=5, src=0 in cycle 4; inflight=1 in cycle 4, 0 in cycle 5.
- rs_insn_ready=10, rs_dst_tag1=9 at cycle 10 -> wakeup tag 9, src=1 at cycle 14; no other wakeups in cycles 11-13.
- Conflict: RS1 issues tag 7 at cycle 20; at cycle 23 rs_insn_ready=01, tag0=3 -> issue[0]=0 at cycle 23 (slot 24 owned); issue[0]=1 at cycle 24; wakeup tag 7 at cycle 24, tag 3 at cycle 25.
- Both RSs ready at cycle 30, tags 1 (ALU) and 2 (MUL) -> issue=11; wakeup tag 1 at 31, tag 2 at 34; inflight=2 at cycle 31.
- Reset asserted at cycle 41 after a MUL issue at 40 -> no wakeup at cycle 44; inflight=0 and issue=00 while reset is high.
